sleep_request_gen: RTL and testbench

- Power-management requester that drives the sleep_request / wakeup_request inputs of the existing sleep controller.
- Watches core activity, requests sleep after a programmable idle interval, then requests wake-up on timer expiry or an external wake event.
- Closes the handshake by monitoring the controller's sleep-state output.
- Runs on the ungated main clock alongside the sleep controller.

---
 rtl/pm_pkg.sv | 18 +
 rtl/pm_down_timer.sv | 27 ++
 rtl/sleep_request_gen.sv | 169 ++++++++++++++++
 tb/tb_sleep_request_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pm_pkg.sv
// Shared definitions for the power-management sleep/wake requester.
package pm_pkg;

  localparam int unsigned PM_STATE_W = 3;

  typedef enum logic [PM_STATE_W-1:0] {
    ACTIVE     = 3'b000,
    REQ_SLEEP  = 3'b001,
    ASLEEP     = 3'b010,
    REQ_WAKE   = 3'b011,
    HOLDOFF_ST = 3'b100
  } pm_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pm_down_timer.sv
// Loadable down-counter that stops at zero and flags when it holds exactly one.
module pm_down_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_at_one
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_at_one = (r_count == W'(1));

endmodule

// File: rtl/sleep_request_gen.sv
// Drives sleep/wake requests to the sleep controller from core idleness, a wake timer
// and external wake events, closing each handshake on the controller's sleep_state.
module sleep_request_gen
  import pm_pkg::*;
#(
  parameter int unsigned IDLE_W      = 16,
  parameter int unsigned WAKE_W      = 24,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned HOLDOFF     = 8
) (
  input  logic              main_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              core_activity,
  input  logic [IDLE_W-1:0] idle_threshold,
  input  logic [WAKE_W-1:0] wake_interval,
  input  logic              wake_event,
  input  logic              sleep_state,
  output logic              sleep_request,
  output logic              wakeup_request,
  output logic [2:0]        pm_state,
  output logic              ack_error,
  output logic [15:0]       sleep_count
);

  localparam int unsigned ACK_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  // A zero holdoff would never reach one; treat it as a single cycle.
  localparam int unsigned HO_LD = (HOLDOFF == 0) ? 1 : HOLDOFF;
  localparam int unsigned HO_W  = $clog2(HO_LD + 1);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HO_LD);

  pm_state_e         r_state, w_state_d;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_d;
  logic [ACK_W-1:0]  r_ack_cnt, w_ack_cnt_d;
  logic              r_ack_err, w_ack_err_d;
  logic [15:0]       r_sleep_cnt, w_sleep_cnt_d;
  logic              r_sleep_req, r_wake_req;

  logic              w_idle_en, w_idle_hit, w_wake_timed;
  logic              w_wake_load, w_wake_dec, w_wake_at_one;
  logic              w_ho_load, w_ho_dec, w_ho_at_one;

  assign w_idle_en    = enable && (idle_threshold != '0);
  assign w_idle_hit   = w_idle_en && !core_activity &&
                        (r_idle_cnt == (idle_threshold - IDLE_W'(1)));
  assign w_wake_timed = (wake_interval != '0);
  assign w_wake_dec   = (r_state == ASLEEP) && w_wake_timed;
  assign w_ho_dec     = (r_state == HOLDOFF_ST);

  pm_down_timer #(
    .W (WAKE_W)
  ) u_wake_timer (
    .i_clk      (main_clk),
    .i_rst      (rst),
    .i_load     (w_wake_load),
    .i_load_val (wake_interval),
    .i_dec      (w_wake_dec),
    .o_at_one   (w_wake_at_one)
  );

  pm_down_timer #(
    .W (HO_W)
  ) u_holdoff_timer (
    .i_clk      (main_clk),
    .i_rst      (rst),
    .i_load     (w_ho_load),
    .i_load_val (HO_LOAD),
    .i_dec      (w_ho_dec),
    .o_at_one   (w_ho_at_one)
  );

  always_comb begin
    w_state_d     = r_state;
    w_ack_cnt_d   = r_ack_cnt;
    w_ack_err_d   = r_ack_err;
    w_sleep_cnt_d = r_sleep_cnt;
    w_wake_load   = 1'b0;
    w_ho_load     = 1'b0;
    case (r_state)
      ACTIVE: begin
        if (sleep_state) begin
          w_state_d   = ASLEEP;
          w_wake_load = 1'b1;
        end else if (w_idle_hit) begin
          w_state_d   = REQ_SLEEP;
          w_ack_cnt_d = '0;
        end
      end
      REQ_SLEEP: begin
        // The acknowledge takes priority over a late abort.
        if (sleep_state) begin
          w_state_d     = ASLEEP;
          w_wake_load   = 1'b1;
          w_sleep_cnt_d = sat_inc16(r_sleep_cnt);
        end else if (core_activity || !enable) begin
          w_state_d = ACTIVE;
        end else if (r_ack_cnt == ACK_LAST) begin
          w_state_d   = ACTIVE;
          w_ack_err_d = 1'b1;
        end else begin
          w_ack_cnt_d = r_ack_cnt + ACK_W'(1);
        end
      end
      ASLEEP: begin
        if (wake_event || (w_wake_timed && w_wake_at_one)) begin
          w_state_d   = REQ_WAKE;
          w_ack_cnt_d = '0;
        end else if (!sleep_state) begin
          w_state_d = HOLDOFF_ST;
          w_ho_load = 1'b1;
        end
      end
      REQ_WAKE: begin
        // Wake is never abandoned: a timeout only flags the error.
        if (!sleep_state) begin
          w_state_d = HOLDOFF_ST;
          w_ho_load = 1'b1;
        end else if (r_ack_cnt == ACK_LAST) begin
          w_ack_err_d = 1'b1;
        end else begin
          w_ack_cnt_d = r_ack_cnt + ACK_W'(1);
        end
      end
      HOLDOFF_ST: begin
        if (w_ho_at_one) begin
          w_state_d = ACTIVE;
        end
      end
      default: begin
        w_state_d = ACTIVE;
      end
    endcase
  end

  always_comb begin
    w_idle_cnt_d = '0;
    if ((r_state == ACTIVE) && (w_state_d == ACTIVE) && w_idle_en && !core_activity) begin
      w_idle_cnt_d = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge main_clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACTIVE;
      r_idle_cnt  <= '0;
      r_ack_cnt   <= '0;
      r_ack_err   <= 1'b0;
      r_sleep_cnt <= '0;
      r_sleep_req <= 1'b0;
      r_wake_req  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_idle_cnt  <= w_idle_cnt_d;
      r_ack_cnt   <= w_ack_cnt_d;
      r_ack_err   <= w_ack_err_d;
      r_sleep_cnt <= w_sleep_cnt_d;
      r_sleep_req <= (w_state_d == REQ_SLEEP);
      r_wake_req  <= (w_state_d == REQ_WAKE);
    end
  end

  assign sleep_request  = r_sleep_req;
  assign wakeup_request = r_wake_req;
  assign pm_state       = r_state;
  assign ack_error      = r_ack_err;
  assign sleep_count    = r_sleep_cnt;

endmodule

// File: tb/tb_sleep_request_gen.sv
// Self-checking bench for sleep_request_gen: idle-threshold table plus handshake sequences.
module tb_sleep_request_gen;
  import pm_pkg::*;

  logic        main_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        core_activity = 1'b0;
  logic [15:0] idle_threshold = '0;
  logic [23:0] wake_interval = '0;
  logic        wake_event = 1'b0;
  logic        sleep_state = 1'b0;
  logic        sleep_request, wakeup_request, ack_error;
  logic [2:0]  pm_state;
  logic [15:0] sleep_count;

  sleep_request_gen #(
    .IDLE_W      (16),
    .WAKE_W      (24),
    .ACK_TIMEOUT (15),
    .HOLDOFF     (8)
  ) dut (
    .main_clk       (main_clk),
    .rst            (rst),
    .enable         (enable),
    .core_activity  (core_activity),
    .idle_threshold (idle_threshold),
    .wake_interval  (wake_interval),
    .wake_event     (wake_event),
    .sleep_state    (sleep_state),
    .sleep_request  (sleep_request),
    .wakeup_request (wakeup_request),
    .pm_state       (pm_state),
    .ack_error      (ack_error),
    .sleep_count    (sleep_count)
  );

  always #5 main_clk = ~main_clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic        sreq;
    logic        wreq;
    logic [2:0]  st;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [15:0] thr;
    logic        en;
    int          rise;  // edge on which sleep_request rises, 0 = never within the window
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  task automatic compare(input exp_t e);
    n_checks++;
    if (sleep_request === e.sreq && wakeup_request === e.wreq && pm_state === e.st &&
        ack_error === e.err && sleep_count === e.cnt) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got sreq=%0b wreq=%0b st=%0d err=%0b cnt=%0d, want sreq=%0b wreq=%0b st=%0d err=%0b cnt=%0d",
               e.name, sleep_request, wakeup_request, pm_state, ack_error, sleep_count,
               e.sreq, e.wreq, e.st, e.err, e.cnt);
    end
  endtask

  task automatic expect_out(input string name, input logic sreq, input logic wreq,
                            input logic [2:0] st, input logic err, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.sreq = sreq; e.wreq = wreq; e.st = st; e.err = err; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic flush();
    while (sb_q.size() > 0) compare(sb_q.pop_front());
  endtask

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic step();
    tick();
    flush();
  endtask

  task automatic do_reset(input logic [15:0] thr, input logic [23:0] wi, input logic en);
    rst = 1'b1;
    idle_threshold = thr; wake_interval = wi; enable = en;
    core_activity = 1'b0; wake_event = 1'b0; sleep_state = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_sreq(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sleep_request && n < limit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int n;
    int got;

    vecs[0] = '{16'd10, 1'b1, 10};
    vecs[1] = '{16'd1,  1'b1, 1};
    vecs[2] = '{16'd3,  1'b1, 3};
    vecs[3] = '{16'd0,  1'b1, 0};
    vecs[4] = '{16'd5,  1'b0, 0};
    vecs[5] = '{16'd2,  1'b1, 2};

    // Reset values
    do_reset(16'd10, 24'd20, 1'b1);
    expect_out("reset_values", 1'b0, 1'b0, ACTIVE, 1'b0, 16'd0);
    flush();

    // Idle threshold table: edge on which the first sleep request appears
    for (int i = 0; i < 6; i++) begin
      do_reset(vecs[i].thr, 24'd0, vecs[i].en);
      wait_sreq(40, n);
      got = sleep_request ? n : 0;
      n_checks++;
      if (got == vecs[i].rise) n_pass++;
      else $display("FAIL idle_table[%0d]: got rise edge %0d, want %0d", i, got, vecs[i].rise);
    end

    // Idle entry, timer wake, holdoff
    do_reset(16'd10, 24'd20, 1'b1);
    repeat (8) tick();
    expect_out("idle_edge9", 1'b0, 1'b0, ACTIVE, 1'b0, 16'd0);          step();
    expect_out("sreq_rise", 1'b1, 1'b0, REQ_SLEEP, 1'b0, 16'd0);        step();
    expect_out("sreq_hold", 1'b1, 1'b0, REQ_SLEEP, 1'b0, 16'd0);        step();
    sleep_state = 1'b1;
    expect_out("sleep_ack", 1'b0, 1'b0, ASLEEP, 1'b0, 16'd1);           step();
    repeat (18) tick();
    expect_out("asleep_pre_timer", 1'b0, 1'b0, ASLEEP, 1'b0, 16'd1);    step();
    expect_out("timer_wake", 1'b0, 1'b1, REQ_WAKE, 1'b0, 16'd1);        step();
    sleep_state = 1'b0;
    core_activity = 1'b1;
    expect_out("wake_ack", 1'b0, 1'b0, HOLDOFF_ST, 1'b0, 16'd1);        step();
    repeat (6) tick();
    expect_out("holdoff_last", 1'b0, 1'b0, HOLDOFF_ST, 1'b0, 16'd1);    step();
    core_activity = 1'b0;
    expect_out("holdoff_exit", 1'b0, 1'b0, ACTIVE, 1'b0, 16'd1);        step();

    // Activity abort: pulse on edge 5, then one cycle into the request
    do_reset(16'd10, 24'd0, 1'b1);
    repeat (4) tick();
    core_activity = 1'b1;
    tick();
    core_activity = 1'b0;
    repeat (8) tick();
    expect_out("idle_restart", 1'b0, 1'b0, ACTIVE, 1'b0, 16'd0);        step();
    expect_out("req_after_restart", 1'b1, 1'b0, REQ_SLEEP, 1'b0, 16'd0); step();
    core_activity = 1'b1;
    expect_out("activity_abort", 1'b0, 1'b0, ACTIVE, 1'b0, 16'd0);      step();
    core_activity = 1'b0;

    // Event-only wake; acknowledge beats simultaneous activity
    wait_sreq(20, n);
    expect_out("re_request", 1'b1, 1'b0, REQ_SLEEP, 1'b0, 16'd0);
    flush();
    sleep_state = 1'b1;
    core_activity = 1'b1;
    expect_out("ack_beats_activity", 1'b0, 1'b0, ASLEEP, 1'b0, 16'd1);  step();
    core_activity = 1'b0;
    repeat (98) tick();
    expect_out("no_timer_wake", 1'b0, 1'b0, ASLEEP, 1'b0, 16'd1);       step();
    wake_event = 1'b1;
    expect_out("event_wake", 1'b0, 1'b1, REQ_WAKE, 1'b0, 16'd1);        step();
    wake_event = 1'b0;

    // Wake acknowledge never arrives
    repeat (13) tick();
    expect_out("wake_pre_timeout", 1'b0, 1'b1, REQ_WAKE, 1'b0, 16'd1);  step();
    expect_out("wake_timeout", 1'b0, 1'b1, REQ_WAKE, 1'b1, 16'd1);      step();
    repeat (5) tick();
    expect_out("wake_held", 1'b0, 1'b1, REQ_WAKE, 1'b1, 16'd1);         step();

    // Asynchronous reset in REQ_WAKE, between edges
    #3;
    rst = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, ACTIVE, 1'b0, 16'd0);
    flush();

    // Sleep acknowledge never arrives; error is sticky across the retry
    do_reset(16'd10, 24'd0, 1'b1);
    repeat (23) tick();
    expect_out("sleep_pre_timeout", 1'b1, 1'b0, REQ_SLEEP, 1'b0, 16'd0); step();
    expect_out("sleep_timeout", 1'b0, 1'b0, ACTIVE, 1'b1, 16'd0);       step();
    repeat (9) tick();
    expect_out("retry_sticky_err", 1'b1, 1'b0, REQ_SLEEP, 1'b1, 16'd0); step();

    // Sleep entered and left externally
    do_reset(16'd0, 24'd0, 1'b1);
    repeat (3) tick();
    sleep_state = 1'b1;
    expect_out("external_sleep", 1'b0, 1'b0, ASLEEP, 1'b0, 16'd0);      step();
    sleep_state = 1'b0;
    expect_out("external_wake", 1'b0, 1'b0, HOLDOFF_ST, 1'b0, 16'd0);   step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
